// File: rtl/motor_ramp_controller.sv
// Motor speed ramp controller: walks the PWM duty level one step per RAMP_PERIOD
// toward a commanded target and inserts a zero-speed dead time before any reversal.
module motor_ramp_controller #(
    parameter int unsigned RAMP_PERIOD = 1024,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic       FPGA_clk,
    input  logic       FPGA_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_speed,
    input  logic       cmd_dir,
    input  logic       estop,
    output logic [3:0] speed,
    output logic       dir,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    localparam logic [15:0] STEP_LAST = 16'(RAMP_PERIOD - 1);
    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  speed_q, speed_d;
    logic        dir_q, dir_d;
    logic [3:0]  tgt_speed_q, tgt_speed_d;
    logic        tgt_dir_q, tgt_dir_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [15:0] dead_cnt_q, dead_cnt_d;
    logic [3:0]  eff_s;

    // One saturating level step from cur toward tgt.
    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        logic [3:0] res;
        res = cur;
        if ((tgt > cur) && (cur != 4'd15)) begin
            res = cur + 4'd1;
        end else if ((tgt < cur) && (cur != 4'd0)) begin
            res = cur - 4'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign cmd_ready = (state_q == ST_IDLE) && !estop;
    assign speed     = speed_q;
    assign dir       = dir_q;
    assign busy      = (state_q != ST_IDLE);

    // Next-state logic: estop overrides everything, otherwise the IDLE/RAMP/DEAD sequence.
    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        dir_d       = dir_q;
        tgt_speed_d = tgt_speed_q;
        tgt_dir_d   = tgt_dir_q;
        step_cnt_d  = step_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        // A pending reversal ramps to zero first.
        eff_s       = (tgt_dir_q != dir_q) ? 4'd0 : tgt_speed_q;

        if (estop) begin
            state_d     = ST_IDLE;
            speed_d     = 4'd0;
            tgt_speed_d = 4'd0;
            step_cnt_d  = 16'd0;
            dead_cnt_d  = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tgt_speed_d = cmd_speed;
                        tgt_dir_d   = cmd_dir;
                        step_cnt_d  = 16'd0;
                        state_d     = ST_RAMP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RAMP: begin
                    if (speed_q == eff_s) begin
                        step_cnt_d = 16'd0;
                        if (tgt_dir_q != dir_q) begin
                            state_d    = ST_DEAD;
                            dead_cnt_d = 16'd0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (step_cnt_q == STEP_LAST) begin
                        speed_d    = step_toward(speed_q, eff_s);
                        step_cnt_d = 16'd0;
                    end else begin
                        step_cnt_d = step_cnt_q + 16'd1;
                    end
                end
                ST_DEAD: begin
                    speed_d = 4'd0;
                    if (dead_cnt_q == DEAD_LAST) begin
                        dir_d      = tgt_dir_q;
                        dead_cnt_d = 16'd0;
                        step_cnt_d = 16'd0;
                        state_d    = ST_RAMP;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    speed_d    = 4'd0;
                    step_cnt_d = 16'd0;
                    dead_cnt_d = 16'd0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge FPGA_clk) begin
        if (FPGA_reset) begin
            state_q     <= ST_IDLE;
            speed_q     <= 4'd0;
            dir_q       <= 1'b0;
            tgt_speed_q <= 4'd0;
            tgt_dir_q   <= 1'b0;
            step_cnt_q  <= 16'd0;
            dead_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            dir_q       <= dir_d;
            tgt_speed_q <= tgt_speed_d;
            tgt_dir_q   <= tgt_dir_d;
            step_cnt_q  <= step_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
        end
    end

endmodule

// File: tb/tb_motor_ramp_controller.sv
// Scoreboard bench for motor_ramp_controller: a trajectory model predicts per-cycle
// speed/dir/busy, a negedge monitor compares DUT outputs against the queued predictions.
module tb_motor_ramp_controller;

    localparam int P = 4;
    localparam int D = 2;

    logic       FPGA_clk;
    logic       FPGA_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_speed;
    logic       cmd_dir;
    logic       estop;
    logic [3:0] speed;
    logic       dir;
    logic       busy;

    typedef struct {
        logic [3:0] speed;
        logic       dir;
        logic       busy;
    } exp_t;

    exp_t traj[$];
    exp_t exp_q[$];

    logic [3:0] m_speed;
    logic       m_dir;
    logic       m_busy;
    bit         started;
    int         checks;
    int         fails;

    motor_ramp_controller #(.RAMP_PERIOD(P), .DEAD_CYCLES(D)) dut (
        .FPGA_clk  (FPGA_clk),
        .FPGA_reset(FPGA_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_speed (cmd_speed),
        .cmd_dir   (cmd_dir),
        .estop     (estop),
        .speed     (speed),
        .dir       (dir),
        .busy      (busy)
    );

    initial FPGA_clk = 1'b0;
    always #5 FPGA_clk = ~FPGA_clk;

    function automatic exp_t mk(input int sp, input logic d, input logic b);
        exp_t e;
        e.speed = 4'(sp);
        e.dir   = d;
        e.busy  = b;
        return e;
    endfunction

    // Whole-command trajectory: one entry per edge starting at the acceptance edge.
    task automatic build_traj(input int s0, input logic d0, input int ts, input logic td);
        int n;
        if (td == d0) begin
            n = (ts > s0) ? ts - s0 : s0 - ts;
            for (int j = 0; j <= P * n; j++)
                traj.push_back(mk((ts > s0) ? s0 + j / P : s0 - j / P, d0, 1'b1));
            traj.push_back(mk(ts, d0, 1'b0));
        end else begin
            for (int j = 0; j <= P * s0; j++)
                traj.push_back(mk(s0 - j / P, d0, 1'b1));
            for (int j = 1; j <= D; j++)
                traj.push_back(mk(0, d0, 1'b1));
            for (int k = 0; k <= P * ts; k++)
                traj.push_back(mk(k / P, td, 1'b1));
            traj.push_back(mk(ts, td, 1'b0));
        end
    endtask

    // Reference model: decides each edge's outcome and queues the expected outputs.
    initial begin
        exp_t e;
        started = 1'b0;
        m_speed = 4'd0;
        m_dir   = 1'b0;
        m_busy  = 1'b0;
        forever begin
            @(posedge FPGA_clk);
            if (FPGA_reset) begin
                started = 1'b1;
                traj.delete();
                m_speed = 4'd0;
                m_dir   = 1'b0;
                m_busy  = 1'b0;
            end else if (estop) begin
                traj.delete();
                m_speed = 4'd0;
                m_busy  = 1'b0;
            end else begin
                if (traj.size() == 0 && cmd_valid)
                    build_traj(int'(m_speed), m_dir, int'(cmd_speed), cmd_dir);
                if (traj.size() != 0) begin
                    e = traj.pop_front();
                    m_speed = e.speed;
                    m_dir   = e.dir;
                    m_busy  = e.busy;
                end
            end
            if (started) exp_q.push_back(mk(int'(m_speed), m_dir, m_busy));
        end
    end

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] expv);
        checks++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, got, expv);
        end
    endtask

    // Monitor: pops one prediction per cycle and compares away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge FPGA_clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("speed", speed, e.speed);
                chk("dir", {3'b000, dir}, {3'b000, e.dir});
                chk("busy", {3'b000, busy}, {3'b000, e.busy});
                chk("cmd_ready", {3'b000, cmd_ready}, {3'b000, (!e.busy && !estop)});
            end
        end
    end

    task automatic tick();
        @(posedge FPGA_clk);
        #1;
    endtask

    // Hold a command until the model says it was taken, then scramble the bus.
    task automatic send_cmd(input logic [3:0] s, input logic d);
        bit acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_speed = s;
        cmd_dir   = d;
        for (int i = 0; i < 2000 && !acc; i++) begin
            acc = (traj.size() == 0) && !estop && !FPGA_reset;
            tick();
        end
        cmd_valid = 1'b0;
        cmd_speed = 4'($urandom);
        cmd_dir   = 1'($urandom);
        checks++;
        if (!acc) begin
            fails++;
            $display("FAIL accept_timeout t=%0t got=0 exp=1", $time);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (traj.size() == 0 && !m_busy) done = 1'b1;
            else tick();
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL idle_timeout t=%0t got=busy exp=idle", $time);
        end
    endtask

    task automatic pulse_estop();
        estop = 1'b1;
        tick();
        estop = 1'b0;
    endtask

    initial begin
        int r;
        checks     = 0;
        fails      = 0;
        FPGA_reset = 1'b1;
        cmd_valid  = 1'b0;
        cmd_speed  = 4'd0;
        cmd_dir    = 1'b0;
        estop      = 1'b0;
        repeat (2) tick();
        FPGA_reset = 1'b0;
        repeat (3) tick();

        // Ramp up, then a reversal through dead time.
        send_cmd(4'd3, 1'b0);
        wait_idle();
        send_cmd(4'd2, 1'b0);
        wait_idle();
        send_cmd(4'd1, 1'b1);
        wait_idle();
        send_cmd(4'd1, 1'b1);
        wait_idle();

        // Second command held while busy, then estop mid-ramp at speed 5.
        send_cmd(4'd0, 1'b0);
        send_cmd(4'd9, 1'b0);
        for (int i = 0; i < 200 && m_speed != 4'd5; i++) tick();
        tick();
        pulse_estop();
        repeat (3) tick();

        // estop together with cmd_valid must not accept.
        cmd_valid = 1'b1;
        cmd_speed = 4'd7;
        estop     = 1'b1;
        tick();
        cmd_valid = 1'b0;
        estop     = 1'b0;
        repeat (3) tick();

        // Reset during dead time aborts the reversal.
        send_cmd(4'd2, 1'b1);
        tick();
        FPGA_reset = 1'b1;
        repeat (2) tick();
        FPGA_reset = 1'b0;
        repeat (12) tick();

        // Randomized command stream with held commands and random estops.
        repeat (25) begin
            repeat ($urandom_range(0, 3)) tick();
            send_cmd(4'($urandom), 1'($urandom));
            r = int'($urandom_range(0, 3));
            if (r == 0) begin
                repeat ($urandom_range(0, 30)) tick();
                pulse_estop();
            end else if (r == 1) begin
                tick();
            end else begin
                wait_idle();
            end
        end
        wait_idle();
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/motor_ramp_controller.md
MOTOR_RAMP_CONTROLLER -- requirements
Module: motor_ramp_controller

Interface
REQ-001 Parameter RAMP_PERIOD, default 1024: clock cycles per one-level speed step, legal range 1..65535.
REQ-002 Parameter DEAD_CYCLES, default 16: cycles held at speed 0 before a direction change, legal range 1..65535.
REQ-003 FPGA_clk  input  1  single clock; all logic on rising edge.
REQ-004 FPGA_reset  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command may be accepted this cycle.
REQ-007 cmd_speed  input  4  target speed level, 0..15.
REQ-008 cmd_dir  input  1  target direction, 0 = forward, 1 = reverse.
REQ-009 estop  input  1  emergency stop, level-sensitive.
REQ-010 speed  output  4  registered duty level driving the PWM generator's speed input.
REQ-011 dir  output  1  registered direction driving the H-bridge.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RAMP, DEAD.
REQ-014 cmd_ready SHALL equal (state==IDLE) AND NOT estop, combinationally.
REQ-015 A command is accepted on an edge where cmd_valid and cmd_ready are both high; the block SHALL then latch tgt_speed = cmd_speed and tgt_dir = cmd_dir, clear step_cnt to 0, and enter RAMP.
REQ-016 Define eff = 0 if tgt_dir != dir, else tgt_speed.
REQ-017 In RAMP with speed == eff: if tgt_dir != dir, go to DEAD with dead_cnt = 0; otherwise go to IDLE; no step occurs in that cycle.
REQ-018 In RAMP with speed != eff: step_cnt SHALL increment each cycle.
REQ-019 When step_cnt == RAMP_PERIOD-1, speed SHALL move exactly one level toward eff and step_cnt SHALL clear.
REQ-020 speed SHALL never wrap past 0 or 15; arithmetic is saturating, with one step at most per period.
REQ-021 In DEAD, speed SHALL stay 0 and dead_cnt SHALL increment each cycle.
REQ-022 When dead_cnt == DEAD_CYCLES-1 in DEAD, dir SHALL load tgt_dir and the FSM SHALL enter RAMP with step_cnt = 0.
REQ-023 dir SHALL change only in the DEAD to RAMP transition, and only while speed == 0.
REQ-024 Commands presented while busy SHALL NOT be accepted and SHALL NOT be dropped; a held cmd_valid is accepted on the first IDLE cycle.
REQ-025 A command equal to the current speed and dir SHALL pass RAMP for one cycle and then return to IDLE.
REQ-026 estop has the highest priority; on any edge where estop is high:
  - speed SHALL be 0 and state SHALL be IDLE;
  - tgt_speed SHALL clear to 0, while dir and tgt_dir are unchanged;
  - step_cnt and dead_cnt SHALL clear.
REQ-027 estop and cmd_valid high together SHALL result in no acceptance.
REQ-028 busy SHALL be derived from the state register; no combinational path SHALL exist from inputs to speed, dir or busy.

Reset
REQ-029 While FPGA_reset is high at a clock edge, the block SHALL set state = IDLE, speed = 0, dir = 0, tgt_speed = 0, tgt_dir = 0, step_cnt = 0 and dead_cnt = 0.
REQ-030 FPGA_reset SHALL take priority over estop and commands.
REQ-031 Reset asserted mid-RAMP or mid-DEAD SHALL abort the sequence with no residual step.
REQ-032 cmd_ready SHALL be 1 on the first cycle after reset release when estop is low.

Verification (RAMP_PERIOD=4, DEAD_CYCLES=2)
REQ-033 Bench SHALL cover: reset held 2 cycles, then released -> speed=0, dir=0, busy=0, cmd_ready=1.
REQ-034 Bench SHALL cover: from idle at speed 0, accept cmd (speed 3, dir 0) at edge E -> speed=1 at E+4, 2 at E+8, 3 at E+12; busy=0 from E+13.
REQ-035 Bench SHALL cover: from speed 2, dir 0, accept cmd (speed 1, dir 1) at E -> speed 1 at E+4, 0 at E+8, DEAD E+9..E+10, dir=1 at E+11, speed 1 at E+15, idle at E+16.
REQ-036 Bench SHALL cover: estop pulsed 1 cycle mid-ramp at speed 5 -> next edge speed=0, busy=0, dir unchanged; cmd_ready low during the estop cycle, high after it.
REQ-037 Bench SHALL cover: second cmd_valid held high during busy -> cmd_ready=0 until IDLE, then accepted exactly once with its values latched.
REQ-038 Bench SHALL cover: FPGA_reset asserted in DEAD with tgt_dir=1 -> after release dir=0, speed=0, and no ramp resumes.
